dram_l2_fill_asm: RTL and testbench
===================================

Name: dram_l2_fill_asm

Overview:
- Receive side of the DRAM-to-L2 read-return path, directly downstream of the DRAM-to-L2 channel buffer.
- Consumes the r0-stage control (data_vld, chunk_id, rd_req_id) and the r2-stage payload (128b data, 28b ECC, secc/mecc flags).
- Aligns control to payload, assembles four 128b chunks into one 64B fill line, accumulates error status, and presents the completed line to scbuf/sctag through a valid/ready handshake.

Parameters:
- DATA_W, 128, chunk data width
- ECC_W, 28, chunk ECC width
- NCHUNK, 4, chunks per line; chunk index width is log2(NCHUNK)
- ID_W, 3, read request id width
- ALIGN_DLY, 2, cycles from r0 control to r2 payload

Ports:
- rclk  in  1  clock
- reset  in  1  synchronous active-high reset
- dram_sctag_data_vld_r0  in  1  chunk valid, r0 stage
- dram_sctag_chunk_id_r0  in  2  chunk index, r0 stage
- dram_sctag_rd_req_id_r0  in  ID_W  request id, r0 stage
- dram_scbuf_data_r2  in  DATA_W  chunk data, r2 stage
- dram_scbuf_ecc_r2  in  ECC_W  chunk ECC, r2 stage
- dram_sctag_secc_err_r2  in  1  correctable error on this chunk
- dram_sctag_mecc_err_r2  in  1  uncorrectable error on this chunk
- fill_vld  out  1  completed line available
- fill_rdy  in  1  consumer accepts line
- fill_data  out  NCHUNK*DATA_W  line data; chunk k at bits [k*DATA_W +: DATA_W]
- fill_ecc  out  NCHUNK*ECC_W  line ECC, same packing
- fill_req_id  out  ID_W  request id of the line
- fill_secc  out  1  OR of chunk secc flags
- fill_mecc  out  1  OR of chunk mecc flags
- crit_vld  out  1  first chunk of a line forwarded (optional feature)
- crit_data  out  DATA_W  forwarded chunk data
- crit_chunk_id  out  2  forwarded chunk index
- fill_ovf_err  out  1  sticky: line lost, output slot full
- fill_proto_err  out  1  sticky: duplicate chunk or id mismatch

Behaviour:
- Clock and reset: one clock, rclk. reset is synchronous and active-high.
- Reset: all outputs 0; chunk mask 0; alignment pipe cleared. Reset mid-line discards the partial line and any held output line.
- Alignment: {vld, chunk_id, req_id} pass through an ALIGN_DLY-deep flop pipe. A chunk is captured in the cycle the delayed vld is 1, together with the r2 payload in that same cycle.
- Fill buffer state IDLE/FILLING, 4-bit chunk mask:
  - IDLE, capture: store the chunk at slot chunk_id; latch req_id; errors = chunk flags; mask = onehot(chunk_id); go to FILLING.
  - FILLING, capture: store the chunk; OR in its flags; set its mask bit.
  - Chunks may arrive in any order.
  - A chunk whose mask bit is already set still overwrites the slot and sets fill_proto_err.
  - A req_id that differs from the latched id sets fill_proto_err; the chunk is stored and the latched id is kept.
  - Mask all-ones (including the capture cycle) → line complete; transfer to the output slot the next edge; return to IDLE with mask cleared.
- Output slot:
  - fill_vld rises 1 cycle after the completing capture, i.e. ALIGN_DLY+1 cycles after the last r0 valid.
  - fill_* outputs stay stable while fill_vld=1 and fill_rdy=0.
  - A transfer completes on any edge with fill_vld&fill_rdy.
- Simultaneous events:
  - Completion in the same cycle as output handoff (fill_vld&fill_rdy): the new line loads and fill_vld stays 1. Back-to-back lines are supported.
  - Completion while the output slot is full and fill_rdy=0: the new line is dropped, fill_ovf_err is set, and the held line is kept. DRAM cannot be backpressured.
- Chunks of the next line may arrive while the previous line sits in the output slot. Fill buffer and output slot are independent (2-entry).
- Sticky errors clear only on reset.

Optional Feature:
- Macro: DRAM_L2_FILL_CRIT_FWD_EN.
- Defined: on the capture that takes the fill buffer IDLE→FILLING, crit_vld=1 for exactly one cycle, registered, 1 cycle after capture. crit_data and crit_chunk_id carry that chunk. No handshake.
- Undefined: crit_vld, crit_data and crit_chunk_id tied to 0; no extra flops.

Decomposition:
- Package dram_l2_pkg: DATA_W/ECC_W/NCHUNK/ID_W constants, chunk_t struct {data, ecc}, fill_state_e {IDLE, FILLING}.
- One sub-module, dram_l2_align_pipe: parameterised delay line for the r0 control bundle, reset to 0.

Test Plan:
- In-order line, id=5, chunks 0..3 on consecutive r0 cycles, data 0xA0..0xA3, fill_rdy=1 → fill_vld high at cycle (last r0)+3; fill_data chunk k = 0xAk; fill_req_id=5; secc=mecc=0.
- Critical-first order 2,3,0,1; mecc on chunk 3 only → line assembled correctly, fill_mecc=1, fill_secc=0; with the macro defined, crit_vld pulses once with crit_chunk_id=2.
- fill_rdy=0 for 20 cycles, then a second full line id=1 → second line dropped, fill_ovf_err=1, first line unchanged; fill_rdy=1 drains the first line.
- Back-to-back lines id=2 then id=3, fill_rdy=1 throughout → two fill_vld transfers, no gap beyond arrival spacing, no errors.
- Chunk 1 sent twice, then chunk 2 carrying id 4 while the line latched id 6 → fill_proto_err=1; the line completes after chunks 0 and 3 arrive with fill_req_id=6.
- reset asserted after 2 of 4 chunks → next cycle all outputs 0; a subsequent full line assembles with no stale chunks.

Source files
------------

// File: rtl/dram_l2_pkg.sv
// Shared constants and types for the DRAM-to-L2 fill assembler.
package dram_l2_pkg;

  localparam int DATA_W    = 128;
  localparam int ECC_W     = 28;
  localparam int NCHUNK    = 4;
  localparam int ID_W      = 3;
  localparam int ALIGN_DLY = 2;
  localparam int CID_W     = $clog2(NCHUNK);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ECC_W-1:0]  ecc;
  } chunk_t;

  typedef enum logic {
    IDLE    = 1'b0,
    FILLING = 1'b1
  } fill_state_e;

  typedef struct packed {
    logic             vld;
    logic [CID_W-1:0] chunk_id;
    logic [ID_W-1:0]  req_id;
  } ctl_t;

  function automatic logic [NCHUNK-1:0] chunk_onehot(input logic [CID_W-1:0] id);
    return {{(NCHUNK-1){1'b0}}, 1'b1} << id;
  endfunction

endpackage

// File: rtl/dram_l2_align_pipe.sv
// Fixed-latency delay line that brings the r0 control bundle in step with the r2 payload.
module dram_l2_align_pipe #(
  parameter int W   = 1,
  parameter int DLY = 2
) (
  input  logic         rclk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_pipe [DLY];

  // NOTE: state is updated with <= so every stage samples its neighbour's old value.
  always_ff @(posedge rclk) begin
    if (reset) begin
      for (int i = 0; i < DLY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= d;
      for (int i = 1; i < DLY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign q = r_pipe[DLY-1];

endmodule

// File: rtl/dram_l2_fill_asm.sv
// Assembles four r2 chunks into one 64B L2 fill line with a one-entry output slot.
// Optional critical-chunk forwarding is enabled with DRAM_L2_FILL_CRIT_FWD_EN.
module dram_l2_fill_asm
  import dram_l2_pkg::*;
(
  input  logic                     rclk,
  input  logic                     reset,
  input  logic                     dram_sctag_data_vld_r0,
  input  logic [CID_W-1:0]         dram_sctag_chunk_id_r0,
  input  logic [ID_W-1:0]          dram_sctag_rd_req_id_r0,
  input  logic [DATA_W-1:0]        dram_scbuf_data_r2,
  input  logic [ECC_W-1:0]         dram_scbuf_ecc_r2,
  input  logic                     dram_sctag_secc_err_r2,
  input  logic                     dram_sctag_mecc_err_r2,
  output logic                     fill_vld,
  input  logic                     fill_rdy,
  output logic [NCHUNK*DATA_W-1:0] fill_data,
  output logic [NCHUNK*ECC_W-1:0]  fill_ecc,
  output logic [ID_W-1:0]          fill_req_id,
  output logic                     fill_secc,
  output logic                     fill_mecc,
  output logic                     crit_vld,
  output logic [DATA_W-1:0]        crit_data,
  output logic [CID_W-1:0]         crit_chunk_id,
  output logic                     fill_ovf_err,
  output logic                     fill_proto_err
);

  ctl_t w_ctl_r0;
  ctl_t w_ctl_r2;

  assign w_ctl_r0 = {dram_sctag_data_vld_r0, dram_sctag_chunk_id_r0, dram_sctag_rd_req_id_r0};

  dram_l2_align_pipe #(
    .W   ($bits(ctl_t)),
    .DLY (ALIGN_DLY)
  ) u_align_pipe (
    .rclk  (rclk),
    .reset (reset),
    .d     (w_ctl_r0),
    .q     (w_ctl_r2)
  );

  fill_state_e              r_state;
  fill_state_e              w_state_nxt;
  logic [NCHUNK-1:0]        r_mask;
  logic [NCHUNK-1:0]        w_mask_nxt;
  logic [NCHUNK-1:0]        w_onehot;
  logic [ID_W-1:0]          r_id;
  logic [ID_W-1:0]          w_id_nxt;
  logic                     r_secc;
  logic                     r_mecc;
  logic                     w_secc_nxt;
  logic                     w_mecc_nxt;
  logic                     w_cap;
  logic                     w_complete;
  logic                     w_proto;
  chunk_t                   w_chunk;
  chunk_t                   r_buf [NCHUNK];
  logic [NCHUNK*DATA_W-1:0] w_line_data;
  logic [NCHUNK*ECC_W-1:0]  w_line_ecc;

  always_ff @(posedge rclk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_cap       = w_ctl_r2.vld;
    w_onehot    = chunk_onehot(w_ctl_r2.chunk_id);
    w_chunk     = '{data: dram_scbuf_data_r2, ecc: dram_scbuf_ecc_r2};
    w_mask_nxt  = w_onehot;
    w_id_nxt    = w_ctl_r2.req_id;
    w_secc_nxt  = dram_sctag_secc_err_r2;
    w_mecc_nxt  = dram_sctag_mecc_err_r2;
    w_proto     = 1'b0;

    if (r_state == FILLING) begin
      w_mask_nxt = r_mask | w_onehot;
      w_id_nxt   = r_id;
      w_secc_nxt = r_secc | dram_sctag_secc_err_r2;
      w_mecc_nxt = r_mecc | dram_sctag_mecc_err_r2;
      w_proto    = w_cap && ((|(r_mask & w_onehot)) || (w_ctl_r2.req_id != r_id));
    end

    w_complete = w_cap && (&w_mask_nxt);
    if (w_cap) w_state_nxt = w_complete ? IDLE : FILLING;

    // The completing chunk bypasses the buffer so the line can hand off on the capture edge.
    for (int k = 0; k < NCHUNK; k++) begin
      w_line_data[k*DATA_W +: DATA_W] = w_onehot[k] ? w_chunk.data : r_buf[k].data;
      w_line_ecc[k*ECC_W +: ECC_W]    = w_onehot[k] ? w_chunk.ecc  : r_buf[k].ecc;
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      r_mask <= '0;
      r_id   <= '0;
      r_secc <= 1'b0;
      r_mecc <= 1'b0;
    end else if (w_cap) begin
      r_mask <= w_complete ? '0 : w_mask_nxt;
      r_id   <= w_id_nxt;
      r_secc <= w_secc_nxt;
      r_mecc <= w_mecc_nxt;
    end
  end

  // NOTE: chunk storage is not reset; the mask decides which slots hold live data.
  always_ff @(posedge rclk) begin
    if (w_cap) r_buf[w_ctl_r2.chunk_id] <= w_chunk;
  end

  logic                     r_fill_vld;
  logic [NCHUNK*DATA_W-1:0] r_fill_data;
  logic [NCHUNK*ECC_W-1:0]  r_fill_ecc;
  logic [ID_W-1:0]          r_fill_id;
  logic                     r_fill_secc;
  logic                     r_fill_mecc;
  logic                     r_ovf_err;
  logic                     r_proto_err;
  logic                     w_slot_free;

  assign w_slot_free = !r_fill_vld || fill_rdy;

  always_ff @(posedge rclk) begin
    if (reset) begin
      r_fill_vld  <= 1'b0;
      r_fill_data <= '0;
      r_fill_ecc  <= '0;
      r_fill_id   <= '0;
      r_fill_secc <= 1'b0;
      r_fill_mecc <= 1'b0;
      r_ovf_err   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_complete && w_slot_free) begin
        r_fill_vld  <= 1'b1;
        r_fill_data <= w_line_data;
        r_fill_ecc  <= w_line_ecc;
        r_fill_id   <= w_id_nxt;
        r_fill_secc <= w_secc_nxt;
        r_fill_mecc <= w_mecc_nxt;
      end else if (fill_rdy) begin
        r_fill_vld <= 1'b0;
      end
      // DRAM cannot be stalled, so a line finishing behind a blocked slot is lost.
      if (w_complete && !w_slot_free) r_ovf_err <= 1'b1;
      if (w_proto)                    r_proto_err <= 1'b1;
    end
  end

  assign fill_vld       = r_fill_vld;
  assign fill_data      = r_fill_data;
  assign fill_ecc       = r_fill_ecc;
  assign fill_req_id    = r_fill_id;
  assign fill_secc      = r_fill_secc;
  assign fill_mecc      = r_fill_mecc;
  assign fill_ovf_err   = r_ovf_err;
  assign fill_proto_err = r_proto_err;

`ifdef DRAM_L2_FILL_CRIT_FWD_EN
  logic              r_crit_vld;
  logic [DATA_W-1:0] r_crit_data;
  logic [CID_W-1:0]  r_crit_id;
  logic              w_crit_start;

  assign w_crit_start = w_cap && (r_state == IDLE);

  always_ff @(posedge rclk) begin
    if (reset) begin
      r_crit_vld  <= 1'b0;
      r_crit_data <= '0;
      r_crit_id   <= '0;
    end else begin
      r_crit_vld <= w_crit_start;
      if (w_crit_start) begin
        r_crit_data <= w_chunk.data;
        r_crit_id   <= w_ctl_r2.chunk_id;
      end
    end
  end

  assign crit_vld      = r_crit_vld;
  assign crit_data     = r_crit_data;
  assign crit_chunk_id = r_crit_id;
`else
  assign crit_vld      = 1'b0;
  assign crit_data     = '0;
  assign crit_chunk_id = '0;
`endif

endmodule

// File: tb/tb_dram_l2_fill_asm.sv
// Scoreboard bench for dram_l2_fill_asm: expected lines are queued at stimulus time and popped on handshake.
module tb_dram_l2_fill_asm;
  import dram_l2_pkg::*;

  typedef struct packed {
    logic [NCHUNK*DATA_W-1:0] data;
    logic [NCHUNK*ECC_W-1:0]  ecc;
    logic [ID_W-1:0]          id;
    logic                     secc;
    logic                     mecc;
  } exp_t;

  logic                     rclk = 1'b0;
  logic                     reset;
  logic                     vld_r0;
  logic [CID_W-1:0]         cid_r0;
  logic [ID_W-1:0]          id_r0;
  logic [DATA_W-1:0]        data_r2;
  logic [ECC_W-1:0]         ecc_r2;
  logic                     secc_r2;
  logic                     mecc_r2;
  logic                     fill_vld;
  logic                     fill_rdy;
  logic [NCHUNK*DATA_W-1:0] fill_data;
  logic [NCHUNK*ECC_W-1:0]  fill_ecc;
  logic [ID_W-1:0]          fill_req_id;
  logic                     fill_secc;
  logic                     fill_mecc;
  logic                     crit_vld;
  logic [DATA_W-1:0]        crit_data;
  logic [CID_W-1:0]         crit_chunk_id;
  logic                     fill_ovf_err;
  logic                     fill_proto_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int crit_cnt = 0;
  logic [CID_W-1:0]  crit_last_id;
  logic [DATA_W-1:0] crit_last_data;
  exp_t sb[$];
  int   hs_cyc[$];

  // Bench-side payload pipe: r2 payload follows its r0 control by ALIGN_DLY cycles.
  logic [DATA_W-1:0] pend_d, hist_d;
  logic [ECC_W-1:0]  pend_e, hist_e;
  logic              pend_s, hist_s, pend_m, hist_m;

  always #5 rclk = ~rclk;
  always @(posedge rclk) cyc++;

  dram_l2_fill_asm dut (
    .rclk                    (rclk),
    .reset                   (reset),
    .dram_sctag_data_vld_r0  (vld_r0),
    .dram_sctag_chunk_id_r0  (cid_r0),
    .dram_sctag_rd_req_id_r0 (id_r0),
    .dram_scbuf_data_r2      (data_r2),
    .dram_scbuf_ecc_r2       (ecc_r2),
    .dram_sctag_secc_err_r2  (secc_r2),
    .dram_sctag_mecc_err_r2  (mecc_r2),
    .fill_vld                (fill_vld),
    .fill_rdy                (fill_rdy),
    .fill_data               (fill_data),
    .fill_ecc                (fill_ecc),
    .fill_req_id             (fill_req_id),
    .fill_secc               (fill_secc),
    .fill_mecc               (fill_mecc),
    .crit_vld                (crit_vld),
    .crit_data               (crit_data),
    .crit_chunk_id           (crit_chunk_id),
    .fill_ovf_err            (fill_ovf_err),
    .fill_proto_err          (fill_proto_err)
  );

  function automatic logic [DATA_W-1:0] cdat(input logic [7:0] base, input int k);
    logic [7:0] b;
    b = base + 8'(k);
    return {8'(k), 88'h5A5A_0000, 24'h0, b};
  endfunction

  function automatic logic [ECC_W-1:0] cecc(input logic [7:0] base, input int k);
    return {12'h0, base, 8'(k)};
  endfunction

  function automatic exp_t make_exp(input logic [ID_W-1:0] id, input logic [7:0] base,
                                    input logic s, input logic m);
    exp_t e;
    for (int k = 0; k < NCHUNK; k++) begin
      e.data[k*DATA_W +: DATA_W] = cdat(base, k);
      e.ecc[k*ECC_W +: ECC_W]    = cecc(base, k);
    end
    e.id   = id;
    e.secc = s;
    e.mecc = m;
    return e;
  endfunction

  always @(negedge rclk) begin : monitor
    exp_t e;
    if (!reset && fill_vld && fill_rdy) begin
      n_tests++;
      hs_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: line id=%0d delivered, no line expected", fill_req_id);
      end else begin
        e = sb.pop_front();
        if ({fill_data, fill_ecc, fill_req_id, fill_secc, fill_mecc} !== e) begin
          n_fail++;
          $display("FAIL sb_line: got id=%0d secc=%b mecc=%b data=%h, expected id=%0d secc=%b mecc=%b data=%h",
                   fill_req_id, fill_secc, fill_mecc, fill_data, e.id, e.secc, e.mecc, e.data);
        end
      end
    end
    if (crit_vld) begin
      crit_cnt++;
      crit_last_id   = crit_chunk_id;
      crit_last_data = crit_data;
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
    data_r2 = hist_d; ecc_r2 = hist_e; secc_r2 = hist_s; mecc_r2 = hist_m;
    hist_d  = pend_d; hist_e = pend_e; hist_s  = pend_s; hist_m  = pend_m;
    pend_d  = '0;     pend_e = '0;     pend_s  = 1'b0;   pend_m  = 1'b0;
    vld_r0  = 1'b0;   cid_r0 = '0;     id_r0   = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic step(input logic [CID_W-1:0] cid, input logic [ID_W-1:0] id,
                      input logic [DATA_W-1:0] d, input logic [ECC_W-1:0] e,
                      input logic s, input logic m);
    vld_r0 = 1'b1; cid_r0 = cid; id_r0 = id;
    pend_d = d; pend_e = e; pend_s = s; pend_m = m;
    tick();
  endtask

  // ord is listed in send order: the leftmost pair goes first.
  task automatic send_line(input logic [ID_W-1:0] id, input logic [7:0] base,
                           input logic [3:0][1:0] ord, input logic [3:0] smask,
                           input logic [3:0] mmask, input bit push);
    if (push) sb.push_back(make_exp(id, base, |smask, |mmask));
    for (int i = 3; i >= 0; i--)
      step(ord[i], id, cdat(base, int'(ord[i])), cecc(base, int'(ord[i])),
           smask[ord[i]], mmask[ord[i]]);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d lines still pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    @(negedge rclk);
    n_tests++;
    if ({fill_vld, fill_data, fill_ecc, fill_req_id, fill_secc, fill_mecc, crit_vld,
         crit_data, crit_chunk_id, fill_ovf_err, fill_proto_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: vld=%b id=%0d ovf=%b proto=%b crit=%b, expected all 0",
               fill_vld, fill_req_id, fill_ovf_err, fill_proto_err, crit_vld);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_in_order();
    fill_rdy = 1'b1;
    send_line(3'd5, 8'hA0, {2'd0, 2'd1, 2'd2, 2'd3}, 4'b0000, 4'b0000, 1'b1);
    tick();
    @(negedge rclk);
    check_bit("inorder_vld_early", fill_vld, 1'b0);
    tick();
    @(negedge rclk);
    check_bit("inorder_vld_at_3", fill_vld, 1'b1);
    n_tests++;
    if (fill_req_id !== 3'd5) begin
      n_fail++;
      $display("FAIL inorder_req_id: got %0d, expected 5", fill_req_id);
    end
    wait_drain("inorder");
  endtask

  task automatic test_crit_first();
    int c0;
    c0 = crit_cnt;
    fill_rdy = 1'b1;
    send_line(3'd1, 8'h30, {2'd2, 2'd3, 2'd0, 2'd1}, 4'b0000, 4'b1000, 1'b1);
    wait_drain("critfirst");
    check_bit("critfirst_proto", fill_proto_err, 1'b0);
    n_tests++;
`ifdef DRAM_L2_FILL_CRIT_FWD_EN
    if (crit_cnt - c0 != 1) begin
      n_fail++;
      $display("FAIL crit_pulses: got %0d, expected 1", crit_cnt - c0);
    end
    n_tests++;
    if (crit_last_id !== 2'd2 || crit_last_data !== cdat(8'h30, 2)) begin
      n_fail++;
      $display("FAIL crit_payload: got id=%0d data=%h, expected id=2 data=%h",
               crit_last_id, crit_last_data, cdat(8'h30, 2));
    end
`else
    if (crit_cnt - c0 != 0) begin
      n_fail++;
      $display("FAIL crit_pulses: got %0d, expected 0", crit_cnt - c0);
    end
`endif
  endtask

  task automatic test_overflow();
    exp_t held;
    held = make_exp(3'd0, 8'h10, 1'b0, 1'b0);
    fill_rdy = 1'b0;
    send_line(3'd0, 8'h10, {2'd0, 2'd1, 2'd2, 2'd3}, 4'b0000, 4'b0000, 1'b1);
    idle(20);
    check_bit("ovf_before", fill_ovf_err, 1'b0);
    send_line(3'd1, 8'h20, {2'd0, 2'd1, 2'd2, 2'd3}, 4'b0000, 4'b0000, 1'b0);
    idle(4);
    @(negedge rclk);
    check_bit("ovf_flag", fill_ovf_err, 1'b1);
    check_bit("ovf_held_vld", fill_vld, 1'b1);
    n_tests++;
    if ({fill_data, fill_ecc, fill_req_id} !== {held.data, held.ecc, held.id}) begin
      n_fail++;
      $display("FAIL ovf_held_line: got id=%0d data=%h, expected id=0 data=%h",
               fill_req_id, fill_data, held.data);
    end
    fill_rdy = 1'b1;
    wait_drain("ovf");
    tick();
    @(negedge rclk);
    check_bit("ovf_drained_vld", fill_vld, 1'b0);
    check_bit("ovf_sticky", fill_ovf_err, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill_rdy = 1'b1;
    hs_cyc.delete();
    send_line(3'd2, 8'h80, {2'd0, 2'd1, 2'd2, 2'd3}, 4'b0000, 4'b0000, 1'b1);
    send_line(3'd3, 8'h90, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b0001, 4'b0000, 1'b1);
    wait_drain("b2b");
    n_tests++;
    if (hs_cyc.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d transfers, expected 2", hs_cyc.size());
    end else if (hs_cyc[1] - hs_cyc[0] != 4) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles, expected 4", hs_cyc[1] - hs_cyc[0]);
    end
    check_bit("b2b_ovf", fill_ovf_err, 1'b0);
    check_bit("b2b_proto", fill_proto_err, 1'b0);
  endtask

  task automatic test_simultaneous();
    fill_rdy = 1'b0;
    send_line(3'd4, 8'h40, {2'd1, 2'd0, 2'd3, 2'd2}, 4'b0000, 4'b0000, 1'b1);
    send_line(3'd7, 8'h70, {2'd0, 2'd1, 2'd2, 2'd3}, 4'b0000, 4'b0100, 1'b1);
    tick();
    fill_rdy = 1'b1;
    @(negedge rclk);
    check_bit("simul_held_vld", fill_vld, 1'b1);
    tick();
    @(negedge rclk);
    check_bit("simul_new_vld", fill_vld, 1'b1);
    n_tests++;
    if (fill_req_id !== 3'd7) begin
      n_fail++;
      $display("FAIL simul_new_id: got %0d, expected 7", fill_req_id);
    end
    wait_drain("simul");
    check_bit("simul_ovf", fill_ovf_err, 1'b0);
  endtask

  task automatic test_proto();
    exp_t e;
    fill_rdy = 1'b1;
    check_bit("proto_before", fill_proto_err, 1'b0);
    sb.push_back(make_exp(3'd6, 8'hB0, 1'b0, 1'b0));
    step(2'd1, 3'd6, cdat(8'hEE, 1), cecc(8'hEE, 1), 1'b0, 1'b0);
    step(2'd1, 3'd6, cdat(8'hB0, 1), cecc(8'hB0, 1), 1'b0, 1'b0);
    step(2'd2, 3'd4, cdat(8'hB0, 2), cecc(8'hB0, 2), 1'b0, 1'b0);
    step(2'd0, 3'd6, cdat(8'hB0, 0), cecc(8'hB0, 0), 1'b0, 1'b0);
    step(2'd3, 3'd6, cdat(8'hB0, 3), cecc(8'hB0, 3), 1'b0, 1'b0);
    wait_drain("proto");
    check_bit("proto_dup_and_id", fill_proto_err, 1'b1);

    // Id mismatch on its own, no duplicate chunk.
    do_reset();
    check_bit("proto_cleared", fill_proto_err, 1'b0);
    e = make_exp(3'd6, 8'hC0, 1'b0, 1'b0);
    sb.push_back(e);
    step(2'd0, 3'd6, cdat(8'hC0, 0), cecc(8'hC0, 0), 1'b0, 1'b0);
    step(2'd2, 3'd4, cdat(8'hC0, 2), cecc(8'hC0, 2), 1'b0, 1'b0);
    step(2'd1, 3'd6, cdat(8'hC0, 1), cecc(8'hC0, 1), 1'b0, 1'b0);
    step(2'd3, 3'd6, cdat(8'hC0, 3), cecc(8'hC0, 3), 1'b0, 1'b0);
    wait_drain("proto_id");
    check_bit("proto_id_only", fill_proto_err, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill_rdy = 1'b1;
    step(2'd0, 3'd3, cdat(8'h50, 0), cecc(8'h50, 0), 1'b1, 1'b1);
    step(2'd1, 3'd3, cdat(8'h50, 1), cecc(8'h50, 1), 1'b1, 1'b1);
    idle(2);
    reset = 1'b1;
    tick();
    @(negedge rclk);
    n_tests++;
    if ({fill_vld, fill_data, fill_ecc, fill_req_id, fill_secc, fill_mecc, crit_vld,
         crit_data, crit_chunk_id, fill_ovf_err, fill_proto_err} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: vld=%b id=%0d ovf=%b proto=%b crit=%b, expected all 0",
               fill_vld, fill_req_id, fill_ovf_err, fill_proto_err, crit_vld);
    end
    reset = 1'b0;
    tick();
    send_line(3'd1, 8'h60, {2'd2, 2'd3, 2'd0, 2'd1}, 4'b0000, 4'b0000, 1'b1);
    wait_drain("midreset");
    check_bit("midreset_proto", fill_proto_err, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    fill_rdy = 1'b0;
    vld_r0   = 1'b0; cid_r0 = '0; id_r0 = '0;
    data_r2  = '0;   ecc_r2 = '0; secc_r2 = 1'b0; mecc_r2 = 1'b0;
    pend_d   = '0;   pend_e = '0; pend_s  = 1'b0; pend_m  = 1'b0;
    hist_d   = '0;   hist_e = '0; hist_s  = 1'b0; hist_m  = 1'b0;

    test_reset();
    test_in_order();
    test_crit_first();
    test_overflow();
    test_back_to_back();
    test_simultaneous();
    test_proto();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within 100000 time units");
    $fatal(1);
  end

endmodule
